ps2_frame_receiver: RTL
=======================

# ps2_frame_receiver

Synchronous PS/2 receive front end that turns the raw keyboard clock/data lines into validated scancodes in the system clock domain. It samples PS2_clk and PS2_data on clk, glitch-filters the PS/2 clock, deframes 11-bit packets (start, 8 data LSB-first, odd parity, stop), and folds the E0/F0 prefix bytes into flags on the following code. It feeds the key-to-control decoder (flap/pause), replacing any logic clocked directly on PS2_clk.

## Interface
- FILTER_LEN, 8: consecutive equal synchronised samples required before the filtered PS/2 clock changes level (2..16).
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge, mid-frame, before the frame is abandoned (1 ms at 50 MHz).
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- PS2_clk  input  1  raw PS/2 clock from the pin, asynchronous.
- PS2_data  input  1  raw PS/2 data from the pin, asynchronous.
- code  output  8  last complete non-prefix scancode; held until the next one.
- code_valid  output  1  one-cycle strobe, code/break_code/extended are new.
- break_code  output  1  code was preceded by F0 (key release).
- extended  output  1  code was preceded by E0.
- frame_err  output  1  one-cycle strobe on start, stop or parity error.

## Operation
- Reset values: code=0x00, code_valid=0, break_code=0, extended=0, frame_err=0; FSM in IDLE; prefix flags cleared; filtered clock=1.
- Input stage: both pins through 2-FF synchronisers. Filter: shift register of FILTER_LEN synchronised PS2_clk samples; filtered clock goes 0 when all are 0, goes 1 when all are 1, else holds. Pulses shorter than FILTER_LEN cycles are ignored.
- Falling edge = filtered clock 1 in previous cycle, 0 now; synchronised PS2_data sampled in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: edge with data=0 -> DATA, bit count=0. Edge with data=1 -> frame_err pulse, stay IDLE.
  - DATA: each edge shifts data in LSB-first; after 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: on edge: stop=1 and parity OK -> byte accepted; else frame_err. Always -> IDLE.
- Parity OK: XOR of 8 data bits and parity bit = 1 (odd).
- Accepted byte: 0xE0 sets extended-pending; 0xF0 sets break-pending; neither produces code_valid. Any other byte: code<=byte, break_code/extended<=pending flags, code_valid pulse, pending flags cleared.
- frame_err or timeout clears both pending flags.
- Timeout: counter clears on every edge and in IDLE; reaching TIMEOUT_CYCLES in DATA/PARITY/STOP -> IDLE, no outputs, no frame_err.

## Timing
- Latency: code_valid asserts exactly FILTER_LEN+3 clk cycles after the raw PS2_clk falling edge of the stop bit (2 sync + FILTER_LEN filter + 1 output register), given clean inputs.
- code_valid and frame_err never both high; each high for exactly one cycle per frame.
- break_code/extended change only in the code_valid cycle and hold afterwards.
- Reset asserted mid-frame: all state returns to reset values immediately; partial frame discarded; first falling edge after reset release with data=0 starts a new frame.
- Simultaneous edge and timeout expiry in same cycle: edge wins, counter clears.
- Minimum clk: 16x PS/2 clock rate at FILTER_LEN=8; not checked in hardware.

## Configuration
- PS2_PARITY_CHECK_EN defined: parity checked as above; bad parity -> frame_err, byte dropped.
- Not defined: parity bit sampled but ignored; only start/stop errors raise frame_err; PARITY state retained so frame timing is identical.

## Test plan
- Frame 0x29, good parity -> code=0x29, code_valid 1 cycle at FILTER_LEN+3 after stop edge, break_code=0, extended=0.
- Frames F0, 29 -> single code_valid, code=0x29, break_code=1, extended=0; none for F0.
- Frames E0, F0, 75 -> single code_valid, code=0x75, break_code=1, extended=1.
- Frame 0x76 with parity bit flipped (macro defined) -> frame_err 1 cycle, no code_valid, code stays previous value; undefined -> code=0x76 accepted.
- 5 bits then idle > TIMEOUT_CYCLES, then frame 0x29 -> no output for partial, 0x29 decoded cleanly; 3-cycle PS2_clk glitch mid-frame (FILTER_LEN=8) -> ignored, frame still decodes.
- rst pulsed after bit 4 of a frame -> outputs at reset values, next full frame 0x76 decoded correctly.

Source files
------------

// File: rtl/ps2_frame_receiver_if.sv
// PS/2 receiver bundle: raw pin inputs plus the decoded scancode outputs.
// The receiver takes the master side and the consumer (key decoder) takes the slave side.
interface ps2_frame_receiver_if;
  logic       PS2_clk;
  logic       PS2_data;
  logic [7:0] code;
  logic       code_valid;
  logic       break_code;
  logic       extended;
  logic       frame_err;

  modport master (
    input  PS2_clk, PS2_data,
    output code, code_valid, break_code, extended, frame_err
  );

  modport slave (
    output PS2_clk, PS2_data,
    input  code, code_valid, break_code, extended, frame_err
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 receive front end: synchronise, glitch-filter, deframe, fold E0/F0 prefixes into flags.
// Optional macro PS2_PARITY_CHECK_EN: when defined, bad odd parity raises frame_err and drops the byte.
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_frame_receiver_if.master  rx
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic                  clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic [FILTER_LEN-1:0] filt_sh_q, filt_sh_d;
  logic                  filt_q, filt_d;
  logic                  fall;

  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;      // parity bit lands in [8], data byte in [7:0]
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ext_pend_q, ext_pend_d;
  logic             brk_pend_q, brk_pend_d;
  logic [7:0]       code_q, code_d;
  logic             code_valid_q, code_valid_d;
  logic             break_q, break_d;
  logic             ext_q, ext_d;
  logic             frame_err_q, frame_err_d;
  logic             frame_ok;

  assign filt_sh_d = {filt_sh_q[FILTER_LEN-2:0], clk_s2_q};

  always_comb begin
    filt_d = filt_q;
    if (filt_sh_q == '0)      filt_d = 1'b0;
    else if (&filt_sh_q)      filt_d = 1'b1;
  end

  assign fall = filt_q & ~filt_d;

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = data_s2_q & (^shift_q);
`else
  assign frame_ok = data_s2_q;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmo_d        = tmo_q;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    code_d       = code_q;
    break_d      = break_q;
    ext_d        = ext_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    // An edge in the same cycle as expiry wins and restarts the count.
    if (fall || state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d      = '0;
      state_d    = ST_IDLE;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s2_q, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          shift_d = {data_s2_q, shift_q[8:1]};
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (frame_ok) begin
            if (shift_q[7:0] == 8'hE0) begin
              ext_pend_d = 1'b1;
            end else if (shift_q[7:0] == 8'hF0) begin
              brk_pend_d = 1'b1;
            end else begin
              code_d       = shift_q[7:0];
              break_d      = brk_pend_q;
              ext_d        = ext_pend_q;
              code_valid_d = 1'b1;
              ext_pend_d   = 1'b0;
              brk_pend_d   = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      data_s1_q    <= 1'b1;
      data_s2_q    <= 1'b1;
      filt_sh_q    <= '1;
      filt_q       <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 9'd0;
      tmo_q        <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      code_q       <= 8'h00;
      code_valid_q <= 1'b0;
      break_q      <= 1'b0;
      ext_q        <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_s1_q     <= rx.PS2_clk;
      clk_s2_q     <= clk_s1_q;
      data_s1_q    <= rx.PS2_data;
      data_s2_q    <= data_s1_q;
      filt_sh_q    <= filt_sh_d;
      filt_q       <= filt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      break_q      <= break_d;
      ext_q        <= ext_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx.code       = code_q;
  assign rx.code_valid = code_valid_q;
  assign rx.break_code = break_q;
  assign rx.extended   = ext_q;
  assign rx.frame_err  = frame_err_q;

endmodule
